// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver for the BCD adder result.
// Optional: define BCD_DISPLAY_LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module bcd_display_mux #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [3:0] in_units,
   input  logic [3:0] in_tens,
   input  logic       in_error,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   logic [CW-1:0] cnt;
   logic          sel;
   logic [3:0]    units_q, tens_q;
   logic          err_q;
   logic          disp_err;
   logic [3:0]    digit;
   logic [6:0]    seg_nxt;

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'h3F;
         4'd1:    encode = 7'h06;
         4'd2:    encode = 7'h5B;
         4'd3:    encode = 7'h4F;
         4'd4:    encode = 7'h66;
         4'd5:    encode = 7'h6D;
         4'd6:    encode = 7'h7D;
         4'd7:    encode = 7'h07;
         4'd8:    encode = 7'h7F;
         4'd9:    encode = 7'h6F;
         default: encode = SEG_DASH;
      endcase
   endfunction

   // Non-BCD latched digits are treated exactly like an adder error.
   always_comb begin
      disp_err = err_q | (units_q > 4'd9) | (tens_q > 4'd9);
      digit    = sel ? tens_q : units_q;
      seg_nxt  = encode(digit);
      if (disp_err)
         seg_nxt = SEG_DASH;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
      else if (sel && (tens_q == 4'd0))
         seg_nxt = SEG_BLANK;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         sel     <= 1'b0;
         units_q <= 4'd0;
         tens_q  <= 4'd0;
         err_q   <= 1'b0;
         seg     <= SEG_BLANK;
         an      <= 2'b00;
      end else begin
         if (cnt == TC) begin
            cnt <= '0;
            sel <= ~sel;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (in_valid) begin
            units_q <= in_units;
            tens_q  <= in_tens;
            err_q   <= in_error;
         end
         // Output stage uses pre-edge sel/data so an and seg move together.
         an  <= sel ? 2'b10 : 2'b01;
         seg <= seg_nxt;
      end
   end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the two-digit BCD adder result (units digit, tens digit, error flag).
- Captures a result on a strobe and drives a 2-digit time-multiplexed 7-segment display: one shared segment bus, two digit enables.
- A free-running refresh counter alternates the digits.
- An error, or any non-BCD digit, shows dashes on both digits.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is held active; legal range ≥ 2. The counter width is $clog2(REFRESH_DIV).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle strobe; capture the data inputs on this edge.
- in_units  input  4  BCD units digit (adder low digit).
- in_tens  input  4  BCD tens digit (adder high digit).
- in_error  input  1  adder error flag.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- an  output  2  digit enables, one-hot, active-high, registered. an[0] = units, an[1] = tens.

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous, active-high and sampled on the clk rising edge. It has priority over every other input, including in_valid on the same edge.

Reset values:
- cnt = 0, sel = 0, units_q = 0, tens_q = 0, err_q = 0.
- seg = 7'h00, an = 2'b00: both digits dark for the reset cycle only.

Capture:
- When in_valid = 1 on an edge (no reset), load units_q <= in_units, tens_q <= in_tens, err_q <= in_error.
- When in_valid = 0, hold all three.
- Any number of back-to-back strobes is legal; the last one wins.

Refresh counter:
- cnt counts 0 .. REFRESH_DIV-1 and wraps to 0.
- On the terminal-count edge (cnt == REFRESH_DIV-1), sel toggles.
- Each digit is therefore active for exactly REFRESH_DIV cycles; the full frame is 2*REFRESH_DIV cycles.
- in_valid does not reset or affect cnt or sel.

Output register, every non-reset edge:
- an <= (sel == 0) ? 2'b01 : 2'b10, using the pre-edge value of sel.
- seg <= encode(selected digit), using the pre-edge values of sel, units_q, tens_q and err_q.
- Latency: data strobed on edge N appears on seg after edge N+1. A sel toggle on edge N appears on an/seg after edge N+1. an and seg always change together.

Display error:
- disp_err = err_q OR (units_q > 9) OR (tens_q > 9).
- When disp_err = 1, both digits show a dash (7'h40).

Encoding (hex):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.

Boundary cases:
- Strobe on the terminal-count edge: both the capture and the sel toggle occur on that edge.
- Reset asserted mid-frame: the next frame restarts at the units digit with a full REFRESH_DIV hold.
- Reset is followed by display of "00" until the first strobe.

Optional Feature:
- Macro: BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: when disp_err = 0 and tens_q == 0, the tens digit outputs seg = 7'h00. an[1] still asserts during its slot so the frame timing is unchanged. The units digit is never blanked, so 0 shows as "0".
- Undefined: tens_q == 0 shows "0" (7'h3F).

Test Plan (REFRESH_DIV = 4):
- Reset held 2 cycles, then released -> seg=00/an=00 during reset. After the first post-reset edge, seg=3F/an=01 for 4 cycles, then seg=3F/an=10 for 4 cycles, repeating.
- Strobe units=7, tens=1, err=0 -> from edge N+1: units slot seg=07, tens slot seg=06. an period = 8 cycles.
- Strobe err=1 with units=3, tens=0; then a strobe with units=4'hA, err=0 -> both slots seg=40 in both cases. A later strobe units=5, tens=0, err=0 -> 6D / 3F, or 6D / 00 with the macro defined.
- Strobe issued exactly on cnt==3 -> an flips and seg shows the new data in the same cycle, one edge later. No glitch cycle with stale data on the new digit.
- Reset asserted during the tens slot together with in_valid (units=9) -> in_valid is ignored, latches = 0. The units slot follows with seg=3F for a full 4 cycles.
- Back-to-back strobes 2,3,4 on consecutive edges -> seg shows only 5B, 4F, 66 sequentially in the units slot. The final held value is 66.
